// File: rtl/axis_detector_arbiter_if.sv
// rtl/axis_detector_arbiter_if.sv - stream bundle between detector readers, arbiter and packetizer
// Purpose: groups the per-channel detector event inputs and the merged AXI4-Stream output.
// Signals:
//   s_axis_tdata  - channel i event in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid - per-channel single-cycle event pulse (no tready)
//   m_axis_tdata  - merged event word
//   m_axis_tuser  - source channel of m_axis_tdata
//   m_axis_tvalid - merged output valid
//   m_axis_tready - downstream ready
// Modports: master = arbiter (drives m_axis_*), slave = readers/packetizer side.
interface axis_detector_arbiter_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int CHAN_WIDTH   = 4
);
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_CHANNELS-1:0]            s_axis_tvalid;
  logic [DATA_WIDTH-1:0]              m_axis_tdata;
  logic [CHAN_WIDTH-1:0]              m_axis_tuser;
  logic                               m_axis_tvalid;
  logic                               m_axis_tready;

  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tdata,
    output m_axis_tuser,
    output m_axis_tvalid
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tuser,
    input  m_axis_tvalid
  );
endinterface

// File: rtl/axis_detector_arbiter.sv
// rtl/axis_detector_arbiter.sv - merges detector reader events onto one channel-tagged AXI4-Stream
// Purpose: one holding buffer per channel, round-robin grant onto a registered output stage,
//          delivered/lost event counters.
// Ports:
//   aclk, areset     - clock, synchronous active-high reset
//   cfg_enable       - per-channel enable mask
//   cfg_clear        - pulse; zeroes sts_sent and sts_lost (wins over increments)
//   axis (master)    - per-channel event inputs and merged output stream
//   sts_sent         - delivered words, wrapping
//   sts_lost         - dropped events, saturating
// Option: AXIS_DETECTOR_ARBITER_FIXED_PRIORITY_EN selects fixed lowest-index-first priority
//         instead of round-robin.
module axis_detector_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int CHAN_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_CHANNELS-1:0] cfg_enable,
  input  logic                    cfg_clear,
  axis_detector_arbiter_if.master axis,
  output logic [31:0]             sts_sent,
  output logic [31:0]             sts_lost
);
  typedef enum logic {ST_EMPTY, ST_FULL} out_state_t;

  out_state_t              r_state;
  out_state_t              w_state_next;
  logic [NUM_CHANNELS-1:0] r_buf_valid;
  logic [DATA_WIDTH-1:0]   r_buf_data [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [CHAN_WIDTH-1:0]   r_out_chan;

  logic                    w_fire;
  logic                    w_grant;
  logic                    w_found;
  logic [CHAN_WIDTH-1:0]   w_grant_idx;
  logic [DATA_WIDTH-1:0]   w_grant_data;
  logic [NUM_CHANNELS-1:0] w_granted;
  logic [NUM_CHANNELS-1:0] w_event;
  logic [NUM_CHANNELS-1:0] w_capture;
  logic [NUM_CHANNELS-1:0] w_drop;
  logic [CHAN_WIDTH:0]     w_drop_cnt;
  logic [32:0]             w_lost_sum;

`ifndef AXIS_DETECTOR_ARBITER_FIXED_PRIORITY_EN
  logic [CHAN_WIDTH-1:0]   r_ptr;
`endif

  assign w_fire  = (r_state == ST_FULL) && axis.m_axis_tready;
  assign w_grant = ((r_state == ST_EMPTY) || axis.m_axis_tready) && w_found;

  // Rotating search: first pass only looks at indices at or above the pointer,
  // second pass picks the lowest valid index, which is the wrap-around case.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
`ifndef AXIS_DETECTOR_ARBITER_FIXED_PRIORITY_EN
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!w_found && r_buf_valid[i] && (i >= int'(r_ptr))) begin
        w_found     = 1'b1;
        w_grant_idx = CHAN_WIDTH'(i);
      end
    end
`endif
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!w_found && r_buf_valid[i]) begin
        w_found     = 1'b1;
        w_grant_idx = CHAN_WIDTH'(i);
      end
    end
  end

  // A buffer being drained this cycle may accept a new event in the same cycle.
  always_comb begin
    w_grant_data = '0;
    w_drop_cnt   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_granted[i] = w_grant && (w_grant_idx == CHAN_WIDTH'(i));
      w_event[i]   = axis.s_axis_tvalid[i] && cfg_enable[i];
      w_capture[i] = w_event[i] && (!r_buf_valid[i] || w_granted[i]);
      w_drop[i]    = w_event[i] && r_buf_valid[i] && !w_granted[i];
      if (w_granted[i]) begin
        w_grant_data = r_buf_data[i];
      end
      w_drop_cnt = w_drop_cnt + (CHAN_WIDTH+1)'(w_drop[i]);
    end
    w_lost_sum = {1'b0, sts_lost} + 33'(w_drop_cnt);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_buf_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_capture[i]) begin
          r_buf_valid[i] <= 1'b1;
          r_buf_data[i]  <= axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (w_granted[i] || !cfg_enable[i]) begin
          r_buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Output stage FSM
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_grant) begin
      w_state_next = ST_FULL;
    end else if (w_fire) begin
      w_state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_out_data <= '0;
      r_out_chan <= '0;
    end else if (w_grant) begin
      r_out_data <= w_grant_data;
      r_out_chan <= w_grant_idx;
    end
  end

`ifndef AXIS_DETECTOR_ARBITER_FIXED_PRIORITY_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_grant_idx == CHAN_WIDTH'(NUM_CHANNELS-1)) ? '0 : w_grant_idx + CHAN_WIDTH'(1);
    end
  end
`endif

  always_ff @(posedge aclk) begin
    if (areset || cfg_clear) begin
      sts_sent <= '0;
      sts_lost <= '0;
    end else begin
      sts_sent <= sts_sent + {31'd0, w_fire};
      sts_lost <= w_lost_sum[32] ? '1 : w_lost_sum[31:0];
    end
  end

  assign axis.m_axis_tvalid = (r_state == ST_FULL);
  assign axis.m_axis_tdata  = r_out_data;
  assign axis.m_axis_tuser  = r_out_chan;
endmodule

// File: tb/tb_axis_detector_arbiter.sv
// tb/tb_axis_detector_arbiter.sv - self-checking bench for axis_detector_arbiter
module tb_axis_detector_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [N-1:0]  cfg_enable;
  logic          cfg_clear;
  logic [31:0]   sts_sent;
  logic [31:0]   sts_lost;

  axis_detector_arbiter_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .CHAN_WIDTH(CW)) bus ();

  axis_detector_arbiter #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .CHAN_WIDTH(CW)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cfg_enable (cfg_enable),
    .cfg_clear  (cfg_clear),
    .axis       (bus),
    .sts_sent   (sts_sent),
    .sts_lost   (sts_lost)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Stimulus applied for the next clock edge
  logic [N-1:0]  in_valid;
  logic [DW-1:0] in_data [N];
  logic          in_ready;

  // Reference model: per-channel one-slot mailbox, one output slot, next-to-serve channel
  bit            m_pend_v [N];
  logic [DW-1:0] m_pend_d [N];
  bit            m_out_v;
  logic [DW-1:0] m_out_d;
  int            m_out_c;
  int            m_ptr;
  longint        m_sent;
  longint        m_lost;

  task automatic model_reset();
    for (int c = 0; c < N; c++) m_pend_v[c] = 0;
    m_out_v = 0; m_out_d = '0; m_out_c = 0; m_ptr = 0; m_sent = 0; m_lost = 0;
  endtask

  task automatic model_edge();
    int g;
    int drops;
    bit fire;
    bit was_v [N];
    fire = m_out_v && in_ready;
    g = -1;
    if (!m_out_v || in_ready) begin
      for (int k = 0; k < N; k++) begin
        int c;
`ifdef AXIS_DETECTOR_ARBITER_FIXED_PRIORITY_EN
        c = k;
`else
        c = (m_ptr + k) % N;
`endif
        if (g < 0 && m_pend_v[c]) g = c;
      end
    end
    for (int c = 0; c < N; c++) was_v[c] = m_pend_v[c];
    if (g >= 0) begin
      m_out_v = 1; m_out_d = m_pend_d[g]; m_out_c = g;
      m_pend_v[g] = 0; m_ptr = (g + 1) % N;
    end else if (fire) begin
      m_out_v = 0;
    end
    drops = 0;
    for (int c = 0; c < N; c++) begin
      if (in_valid[c] && cfg_enable[c]) begin
        if (!was_v[c] || c == g) begin
          m_pend_v[c] = 1; m_pend_d[c] = in_data[c];
        end else begin
          drops++;
        end
      end else if (!cfg_enable[c]) begin
        m_pend_v[c] = 0;
      end
    end
    if (cfg_clear) begin
      m_sent = 0; m_lost = 0;
    end else begin
      m_sent = (m_sent + (fire ? 1 : 0)) & 64'hFFFF_FFFF;
      if (m_lost + drops > 64'hFFFF_FFFF) m_lost = 64'hFFFF_FFFF;
      else m_lost = m_lost + drops;
    end
  endtask

  // Drive inputs, advance model and DUT one edge, compare at the falling edge
  task automatic step();
    bus.s_axis_tvalid = in_valid;
    for (int i = 0; i < N; i++) bus.s_axis_tdata[i*DW +: DW] = in_data[i];
    bus.m_axis_tready = in_ready;
    if (areset) model_reset();
    else model_edge();
    @(posedge aclk);
    @(negedge aclk);
    chk("tvalid", bus.m_axis_tvalid, m_out_v);
    if (m_out_v) begin
      chk("tdata", bus.m_axis_tdata, m_out_d);
      chk("tuser", bus.m_axis_tuser, m_out_c);
    end
    chk("sts_sent", sts_sent, m_sent);
    chk("sts_lost", sts_lost, m_lost);
  endtask

  task automatic idle(input int n);
    in_valid = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    areset = 1'b1; in_valid = '0;
    step();
    areset = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    areset = 1'b1; cfg_enable = '1; cfg_clear = 1'b0; in_valid = '0; in_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    bus.s_axis_tvalid = '0; bus.s_axis_tdata = '0; bus.m_axis_tready = 1'b1;
    @(negedge aclk);

    // Reset state
    do_reset();
    chk("rst_tdata", bus.m_axis_tdata, 0);
    chk("rst_tuser", bus.m_axis_tuser, 0);

    // Single event on ch2: visible two edges after the pulse
    idle(8);
    in_data[2] = 128'hAB; in_valid = 4'b0100;
    step();
    in_valid = '0;
    chk("t1_lat_n1", bus.m_axis_tvalid, 0);
    step();
    chk("t1_tvalid", bus.m_axis_tvalid, 1);
    chk("t1_tdata", bus.m_axis_tdata, 128'hAB);
    chk("t1_tuser", bus.m_axis_tuser, 2);
    idle(2);
    chk("t1_sent", sts_sent, 1);

    // Simultaneous burst on all channels, twice: order 0,1,2,3 each time
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) in_data[i] = rnd_data();
      in_valid = '1;
      step();
      in_valid = '0;
      for (int i = 0; i < N; i++) begin
        step();
        chk("burst_tuser", bus.m_axis_tuser, i);
      end
      idle(1);
      chk("burst_sent", sts_sent, 4 * (r + 1));
    end

    // Back-pressure: three ch1 pulses 2 cycles apart, third one lost
    in_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      in_data[1] = rnd_data(); in_valid = 4'b0010;
      step();
      in_valid = '0;
      step();
    end
    chk("bp_lost", sts_lost, 1);
    in_ready = 1'b1;
    idle(4);

    // Same-cycle drain and capture on ch3: no loss
    for (int k = 0; k < 100; k++) begin
      in_data[3] = rnd_data(); in_valid = 4'b1000;
      step();
    end
    idle(3);
    chk("t4_lost", sts_lost, 1);

    // Disabled ch2, then clear coinciding with drops
    cfg_enable = 4'b1011;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) in_data[i] = rnd_data();
      in_valid = 4'($urandom_range(0, 15));
      step();
    end
    in_ready = 1'b0; in_valid = '1;
    step(); step();
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    chk("clr_sent", sts_sent, 0);
    chk("clr_lost", sts_lost, 0);
    in_ready = 1'b1; cfg_enable = '1;
    idle(6);

    // ch0 and ch3 every cycle, then reset mid-burst
    for (int k = 0; k < 30; k++) begin
      in_data[0] = rnd_data(); in_data[3] = rnd_data(); in_valid = 4'b1001;
      step();
    end
    do_reset();
    chk("midrst_tvalid", bus.m_axis_tvalid, 0);
    chk("midrst_sent", sts_sent, 0);
    chk("midrst_lost", sts_lost, 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) in_data[i] = rnd_data();
      in_valid   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      in_ready   = ($urandom_range(0, 3) != 0);
      cfg_enable = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      cfg_clear  = ($urandom_range(0, 49) == 0);
      areset     = ($urandom_range(0, 299) == 0);
      step();
    end
    areset = 1'b0; cfg_clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
